// File: rtl/dmem_arbiter_if.sv
// Shared data-memory port bundle: two requesters on one side, the dmem on the other.
// The arbiter takes the slave view; requesters and memory model take the master view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    logic              a_req;
    logic              a_wren;
    logic              a_lock;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_wren;
    logic              b_lock;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  a_req, a_wren, a_lock, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_wren, b_lock, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output mem_address, mem_data, mem_wren,
        input  mem_q
    );

    modport master (
        output a_req, a_wren, a_lock, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_wren, b_lock, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  mem_address, mem_data, mem_wren,
        output mem_q
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester dmem arbiter: round robin on ties, bounded lock hold,
// single-cycle read latency with per-requester read-data hold.
module dmem_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic           clock,
    input  logic           reset_btn,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    state_t            r_state;
    state_t            w_next;
    logic              r_last_b;
    logic [7:0]        r_hold;
    logic [7:0]        w_hold_nxt;
    logic              w_ga;
    logic              w_gb;
    logic              w_lock_a;
    logic              w_lock_b;
    logic              r_a_rv;
    logic              r_b_rv;
    logic [DATA_W-1:0] r_a_hold;
    logic [DATA_W-1:0] r_b_hold;

    always_comb begin
        w_ga       = 1'b0;
        w_gb       = 1'b0;
        w_next     = IDLE;
        w_hold_nxt = 8'd0;
        w_lock_a   = (r_state == OWN_A) && bus.a_lock && (r_hold < HOLD_MAX);
        w_lock_b   = (r_state == OWN_B) && bus.b_lock && (r_hold < HOLD_MAX);
        if (!reset_btn) begin
            w_ga = 1'b0;
        end else if (bus.a_req && bus.b_req) begin
            // Once the hold limit is hit the owner is also last winner,
            // so round robin alone hands the bus over.
            if (w_lock_a)      w_ga = 1'b1;
            else if (w_lock_b) w_gb = 1'b1;
            else if (r_last_b) w_ga = 1'b1;
            else               w_gb = 1'b1;
        end else begin
            w_ga = bus.a_req;
            w_gb = bus.b_req;
        end
        if (w_ga) w_next = OWN_A;
        if (w_gb) w_next = OWN_B;
        if (w_ga && bus.b_req)
            w_hold_nxt = (r_state == OWN_A) ? r_hold + 8'd1 : 8'd1;
        if (w_gb && bus.a_req)
            w_hold_nxt = (r_state == OWN_B) ? r_hold + 8'd1 : 8'd1;
    end

    always_comb begin
        bus.mem_address = '0;
        bus.mem_data    = '0;
        bus.mem_wren    = 1'b0;
        unique case (1'b1)
            w_ga: begin
                bus.mem_address = bus.a_addr;
                bus.mem_data    = bus.a_wdata;
                bus.mem_wren    = bus.a_wren;
            end
            w_gb: begin
                bus.mem_address = bus.b_addr;
                bus.mem_data    = bus.b_wdata;
                bus.mem_wren    = bus.b_wren;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_btn) begin
        if (!reset_btn) begin
            r_state  <= IDLE;
            r_last_b <= 1'b1;
            r_hold   <= 8'd0;
            r_a_rv   <= 1'b0;
            r_b_rv   <= 1'b0;
            r_a_hold <= '0;
            r_b_hold <= '0;
        end else begin
            r_state <= w_next;
            r_hold  <= w_hold_nxt;
            if (w_ga)      r_last_b <= 1'b0;
            else if (w_gb) r_last_b <= 1'b1;
            r_a_rv <= w_ga & ~bus.a_wren;
            r_b_rv <= w_gb & ~bus.b_wren;
            if (r_a_rv) r_a_hold <= bus.mem_q;
            if (r_b_rv) r_b_hold <= bus.mem_q;
        end
    end

    // mem_q is only valid in the cycle after the address, so it is
    // passed straight through then and captured for later cycles.
    assign bus.a_gnt    = w_ga;
    assign bus.b_gnt    = w_gb;
    assign bus.a_rvalid = r_a_rv;
    assign bus.b_rvalid = r_b_rv;
    assign bus.a_rdata  = r_a_rv ? bus.mem_q : r_a_hold;
    assign bus.b_rdata  = r_b_rv ? bus.mem_q : r_b_hold;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed cycles push expected bus/grant
// values and read data; a negedge monitor pops and compares.
module tb_dmem_arbiter;
    typedef struct packed {
        logic        req;
        logic        wren;
        logic        lock;
        logic [12:0] addr;
        logic [31:0] wdata;
    } rq_t;

    typedef struct packed {
        logic        ga;
        logic        gb;
        logic        wren;
        logic [12:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_btn;
    logic [31:0] mem [0:8191];
    exp_t        cq[$];
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] la = '0;
    logic [31:0] lb = '0;
    int          n_cmp = 0;
    int          n_bad = 0;

    dmem_arbiter_if #(.ADDR_W(13), .DATA_W(32)) bus ();

    dmem_arbiter #(
        .ADDR_W(13),
        .DATA_W(32),
        .MAX_HOLD(4)
    ) u_dut (
        .clock(clock),
        .reset_btn(reset_btn),
        .bus(bus.slave)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bus.mem_wren) mem[bus.mem_address] <= bus.mem_data;
        bus.mem_q <= mem[bus.mem_address];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        logic [31:0] d;
        if (!reset_btn) begin
            la = '0;
            lb = '0;
        end
        if (cq.size() > 0) begin
            e = cq.pop_front();
            chk("a_gnt", 32'(bus.a_gnt), 32'(e.ga));
            chk("b_gnt", 32'(bus.b_gnt), 32'(e.gb));
            chk("mem_wren", 32'(bus.mem_wren), 32'(e.wren));
            chk("mem_address", 32'(bus.mem_address), 32'(e.addr));
            chk("mem_data", bus.mem_data, e.data);
        end
        if (bus.a_rvalid) begin
            if (qa.size() == 0) chk("a_rvalid_unexpected", 32'd1, 32'd0);
            else begin
                d = qa.pop_front();
                chk("a_rdata", bus.a_rdata, d);
                la = d;
            end
        end else if (reset_btn) chk("a_rdata_hold", bus.a_rdata, la);
        if (bus.b_rvalid) begin
            if (qb.size() == 0) chk("b_rvalid_unexpected", 32'd1, 32'd0);
            else begin
                d = qb.pop_front();
                chk("b_rdata", bus.b_rdata, d);
                lb = d;
            end
        end else if (reset_btn) chk("b_rdata_hold", bus.b_rdata, lb);
    end

    function automatic rq_t mk(input logic w, input logic l,
                               input logic [12:0] ad, input logic [31:0] wd);
        rq_t r;
        r.req   = 1'b1;
        r.wren  = w;
        r.lock  = l;
        r.addr  = ad;
        r.wdata = wd;
        return r;
    endfunction

    task automatic drive(input rq_t a, input rq_t b);
        bus.a_req   = a.req;
        bus.a_wren  = a.wren;
        bus.a_lock  = a.lock;
        bus.a_addr  = a.addr;
        bus.a_wdata = a.wdata;
        bus.b_req   = b.req;
        bus.b_wren  = b.wren;
        bus.b_lock  = b.lock;
        bus.b_addr  = b.addr;
        bus.b_wdata = b.wdata;
    endtask

    task automatic step(input rq_t a, input rq_t b, input logic ga,
                        input logic gb, input logic [31:0] rd);
        exp_t e;
        @(posedge clock);
        #1;
        drive(a, b);
        e = '0;
        e.ga = ga;
        e.gb = gb;
        if (ga) begin
            e.wren = a.wren;
            e.addr = a.addr;
            e.data = a.wdata;
        end else if (gb) begin
            e.wren = b.wren;
            e.addr = b.addr;
            e.data = b.wdata;
        end
        cq.push_back(e);
        if (ga && !a.wren) qa.push_back(rd);
        if (gb && !b.wren) qb.push_back(rd);
    endtask

    localparam rq_t NONE = '0;

    initial begin
        rq_t ra20, rb30, rb30l, ra40, ra10, bw, br;
        for (int i = 0; i < 8192; i++) mem[i] = '0;
        mem[13'h010] = 32'hDEADBEEF;
        mem[13'h020] = 32'h11111111;
        mem[13'h030] = 32'h22222222;
        mem[13'h040] = 32'h33333333;
        ra10  = mk(1'b0, 1'b0, 13'h010, 32'hA5A5_0001);
        ra20  = mk(1'b0, 1'b0, 13'h020, 32'hA5A5_0002);
        ra40  = mk(1'b0, 1'b0, 13'h040, 32'hA5A5_0004);
        rb30  = mk(1'b0, 1'b0, 13'h030, 32'h5A5A_0003);
        rb30l = mk(1'b0, 1'b1, 13'h030, 32'h5A5A_0003);
        bw    = mk(1'b1, 1'b0, 13'h1FFF, 32'h12345678);
        br    = mk(1'b0, 1'b0, 13'h1FFF, 32'h0);

        // Reset held with A requesting: grant must stay gated off.
        reset_btn = 1'b0;
        drive(ra10, NONE);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_a_gnt", 32'(bus.a_gnt), 32'd0);
        chk("rst_mem_address", 32'(bus.mem_address), 32'd0);
        chk("rst_mem_data", bus.mem_data, 32'd0);
        chk("rst_mem_wren", 32'(bus.mem_wren), 32'd0);
        chk("rst_a_rvalid", 32'(bus.a_rvalid), 32'd0);
        chk("rst_a_rdata", bus.a_rdata, 32'd0);
        chk("rst_b_rdata", bus.b_rdata, 32'd0);
        @(negedge clock);
        #2;
        drive(NONE, NONE);
        reset_btn = 1'b1;

        // Tie after reset: A first, then alternate.
        step(ra20, rb30, 1'b1, 1'b0, 32'h11111111);
        step(ra20, rb30, 1'b0, 1'b1, 32'h22222222);
        step(ra20, rb30, 1'b1, 1'b0, 32'h11111111);
        step(ra20, rb30, 1'b0, 1'b1, 32'h22222222);

        for (int i = 0; i < 10; i++) step(NONE, NONE, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        chk("idle_hold", 32'(u_dut.r_hold), 32'd0);
        chk("idle_state", 32'(int'(u_dut.r_state)), 32'd0);

        step(ra10, NONE, 1'b1, 1'b0, 32'hDEADBEEF);
        step(NONE, NONE, 1'b0, 1'b0, 32'h0);
        step(NONE, NONE, 1'b0, 1'b0, 32'h0);

        // Write then read back at the top address.
        step(NONE, bw, 1'b0, 1'b1, 32'h0);
        step(NONE, NONE, 1'b0, 1'b0, 32'h0);
        step(NONE, br, 1'b0, 1'b1, 32'h12345678);
        step(NONE, NONE, 1'b0, 1'b0, 32'h0);

        // Lock limit 4: B owns alone, then holds 4 contested cycles.
        step(NONE, rb30l, 1'b0, 1'b1, 32'h22222222);
        for (int i = 0; i < 4; i++)
            step(ra40, rb30l, 1'b0, 1'b1, 32'h22222222);
        step(ra40, rb30l, 1'b1, 1'b0, 32'h33333333);
        step(ra40, rb30l, 1'b0, 1'b1, 32'h22222222);
        step(NONE, NONE, 1'b0, 1'b0, 32'h0);
        step(NONE, NONE, 1'b0, 1'b0, 32'h0);

        // Reset between an A read grant and its data cycle.
        step(ra10, NONE, 1'b1, 1'b0, 32'hDEADBEEF);
        @(negedge clock);
        #2;
        reset_btn = 1'b0;
        qa.delete();
        #1;
        chk("mid_a_gnt", 32'(bus.a_gnt), 32'd0);
        chk("mid_a_rvalid", 32'(bus.a_rvalid), 32'd0);
        chk("mid_mem_address", 32'(bus.mem_address), 32'd0);
        chk("mid_mem_data", bus.mem_data, 32'd0);
        chk("mid_mem_wren", 32'(bus.mem_wren), 32'd0);
        chk("mid_a_rdata", bus.a_rdata, 32'd0);
        @(posedge clock);
        #1;
        chk("mid_a_rvalid_edge", 32'(bus.a_rvalid), 32'd0);
        drive(NONE, NONE);
        @(negedge clock);
        #2;
        reset_btn = 1'b1;
        step(ra20, NONE, 1'b1, 1'b0, 32'h11111111);
        step(NONE, NONE, 1'b0, 1'b0, 32'h0);
        step(NONE, NONE, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        #1;
        chk("qa_drained", 32'(qa.size()), 32'd0);
        chk("qb_drained", 32'(qb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 13, meaning the dmem address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the dmem data width.
REQ-003 The block SHALL have parameter MAX_HOLD, default 8, meaning the maximum consecutive granted cycles under lock while the other requester waits (range 1..255).
REQ-004 The block SHALL have these ports, in this order:
- clock  input  1  single clock; all state on rising edge.
- reset_btn  input  1  asynchronous active-low reset.
- a_req, a_wren, a_lock  input  1 each  processor request, write enable, hold-bus hint.
- a_addr  input  ADDR_W  processor address.
- a_wdata  input  DATA_W  processor write data.
- a_gnt, a_rvalid  output  1 each  processor grant, read-data valid.
- a_rdata  output  DATA_W  processor read data.
- b_req, b_wren, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as a_*  second requester (sprite/DMA engine).
- mem_address  output  ADDR_W  dmem address.
- mem_data  output  DATA_W  dmem write data.
- mem_wren  output  1  dmem write enable.
- mem_q  input  DATA_W  dmem read data, valid one cycle after address.

Function
REQ-005 State machine SHALL have states IDLE, OWN_A, OWN_B; state names the requester granted in the current cycle.
REQ-006 Grant SHALL be combinational from current state, last_winner register, hold counter and this cycle's a_req/b_req; at most one of a_gnt/b_gnt high per cycle.
REQ-007 With exactly one requester asserting req, that requester SHALL be granted that cycle.
REQ-008 With both requesting and no lock in effect, grant SHALL go to the requester that is not last_winner (round robin); after reset last_winner = B, so A wins the first tie.
REQ-009 Lock in effect: current owner has req and lock high, and hold counter < MAX_HOLD; owner then SHALL keep the grant regardless of the other's req.
REQ-010 Hold counter SHALL count consecutive cycles with the same owner granted while the other requester has req high; it SHALL clear on owner change, on a cycle when the other has req low, and in IDLE.
REQ-011 When hold counter reaches MAX_HOLD and the other requester has req high, grant SHALL pass to the other requester on that cycle irrespective of lock.
REQ-012 Granted requester's addr, wdata and wren SHALL drive mem_address, mem_data and mem_wren combinationally in the grant cycle; with no grant, mem_wren = 0 and mem_address/mem_data = 0.
REQ-013 Granted read (wren = 0) SHALL produce rvalid high on that requester for exactly the next cycle with rdata = mem_q; latency is 1 cycle.
REQ-014 Granted write SHALL complete in the grant cycle; rvalid SHALL stay low for writes.
REQ-015 rdata SHALL hold its last value when rvalid is low.
REQ-016 A requester SHALL hold req, addr, wdata and wren stable until it sees gnt; the arbiter SHALL NOT queue requests.
REQ-017 Grant to A and rvalid to B in the same cycle, and vice versa, SHALL be supported; back-to-back reads SHALL sustain one access per cycle.
REQ-018 State SHALL update each rising edge: OWN_A/OWN_B per the grant, IDLE when neither req is high; last_winner SHALL update only on a granted cycle.

Reset
REQ-019 reset_btn low SHALL immediately force state IDLE, last_winner = B, hold counter 0, a_gnt = b_gnt = 0, a_rvalid = b_rvalid = 0, a_rdata = b_rdata = 0, mem_wren = 0, mem_address = 0, mem_data = 0, regardless of clock.
REQ-020 Reset asserted mid-read SHALL cancel the pending rvalid; no rvalid SHALL appear after reset release.
REQ-021 First rising edge after reset_btn rises SHALL arbitrate normally.

Verification
REQ-022 Single read: a_req = 1, a_addr = 0x010, mem_q = 0xDEADBEEF next cycle -> a_gnt same cycle, mem_address = 0x010, a_rvalid = 1 next cycle with a_rdata = 0xDEADBEEF.
REQ-023 Tie after reset: a_req = b_req = 1 continuously, no lock -> grants alternate A, B, A, B; mem_address alternates between a_addr and b_addr.
REQ-024 Lock limit: MAX_HOLD = 4, b_req = b_lock = 1 granted first, a_req = 1 throughout -> B holds 4 cycles, A granted on cycle 5, B regranted on cycle 6.
REQ-025 Write: b_req = b_wren = 1, b_addr = 0x1FFF, b_wdata = 0x12345678 -> mem_wren = 1, mem_address = 0x1FFF, mem_data = 0x12345678 for one cycle; b_rvalid stays 0.
REQ-026 Reset mid-op: A read granted, reset_btn low before the next edge -> a_rvalid = 0, all outputs zero; after release, a_req alone is granted on the first cycle.
REQ-027 Idle: both req = 0 for 10 cycles -> no gnt, mem_wren = 0, hold counter 0, state IDLE.
